// File: rtl/cpu_alu.sv
// Registered 8-bit ALU: one operation per cycle, result and {V,N,Z,C} flags appear one edge later.
// No handshake; synchronous active-high reset clears both outputs.
module cpu_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] operation,
  input  logic [3:0] flagsIn,
  input  logic [7:0] leftOperand,
  input  logic [7:0] rightOperand,
  output logic [7:0] resultOut,
  output logic [3:0] flagsOut
);

  typedef enum logic [3:0] {
    ALUOP_ADD  = 4'h0,
    ALUOP_ADC  = 4'h1,
    ALUOP_SUB  = 4'h2,
    ALUOP_SBC  = 4'h3,
    ALUOP_AND  = 4'h4,
    ALUOP_OR   = 4'h5,
    ALUOP_XOR  = 4'h6,
    ALUOP_CMP  = 4'h7,
    ALUOP_INC  = 4'h8,
    ALUOP_DEC  = 4'h9,
    ALUOP_SHL  = 4'hA,
    ALUOP_SHR  = 4'hB,
    ALUOP_ROL  = 4'hC,
    ALUOP_ROR  = 4'hD,
    ALUOP_NOT  = 4'hE,
    ALUOP_PASS = 4'hF
  } alu_op_e;

  localparam int V_BIT = 3;
  localparam int C_BIT = 0;

  alu_op_e    op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       c_in_keep;
  logic       v_in_keep;

  logic       add_cin;
  logic       sub_cin;
  logic [8:0] add9;
  logic [8:0] sub9;
  logic       add_ovf;
  logic       sub_ovf;

  logic [7:0] result_d;
  logic [7:0] result_q;
  logic [3:0] flags_d;
  logic [3:0] flags_q;

  logic [7:0] zn_src;
  logic       c_new;
  logic       v_new;

  assign op        = alu_op_e'(operation);
  assign a         = leftOperand;
  assign b         = rightOperand;
  assign cin       = flagsIn[C_BIT];
  assign c_in_keep = flagsIn[C_BIT];
  assign v_in_keep = flagsIn[V_BIT];

  // Shared 9-bit adder/subtractor; bit 8 is carry-out or borrow.
  assign add_cin = (op == ALUOP_ADC) ? cin : 1'b0;
  assign sub_cin = (op == ALUOP_SBC) ? cin : 1'b0;
  assign add9    = {1'b0, a} + {1'b0, b} + {8'd0, add_cin};
  assign sub9    = {1'b0, a} - {1'b0, b} - {8'd0, sub_cin};
  assign add_ovf = (a[7] == b[7]) && (add9[7] != a[7]);
  assign sub_ovf = (a[7] != b[7]) && (sub9[7] != a[7]);

  always_comb begin
    result_d = 8'h00;
    c_new    = c_in_keep;
    v_new    = 1'b0;
    zn_src   = 8'h00;

    case (op)
      ALUOP_ADD, ALUOP_ADC: begin
        result_d = add9[7:0];
        c_new    = add9[8];
        v_new    = add_ovf;
      end
      ALUOP_SUB, ALUOP_SBC: begin
        result_d = sub9[7:0];
        c_new    = sub9[8];
        v_new    = sub_ovf;
      end
      ALUOP_AND: result_d = a & b;
      ALUOP_OR:  result_d = a | b;
      ALUOP_XOR: result_d = a ^ b;
      ALUOP_CMP: begin
        result_d = a;
        c_new    = sub9[8];
        v_new    = sub_ovf;
      end
      ALUOP_INC: begin
        result_d = a + 8'd1;
        v_new    = (a == 8'h7F);
      end
      ALUOP_DEC: begin
        result_d = a - 8'd1;
        v_new    = (a == 8'h80);
      end
      ALUOP_SHL: begin
        result_d = {a[6:0], 1'b0};
        c_new    = a[7];
      end
      ALUOP_SHR: begin
        result_d = {1'b0, a[7:1]};
        c_new    = a[0];
      end
      ALUOP_ROL: begin
        result_d = {a[6:0], cin};
        c_new    = a[7];
      end
      ALUOP_ROR: begin
        result_d = {cin, a[7:1]};
        c_new    = a[0];
      end
      ALUOP_NOT: result_d = ~a;
      ALUOP_PASS: begin
        result_d = b;
        v_new    = v_in_keep;
      end
    endcase

    // CMP leaves A on the result bus but reports Z/N of the difference.
    zn_src  = (op == ALUOP_CMP) ? sub9[7:0] : result_d;
    flags_d = {v_new, zn_src[7], (zn_src == 8'h00), c_new};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= 8'h00;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign resultOut = result_q;
  assign flagsOut  = flags_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed-vector bench for cpu_alu; expected values are hand-computed per vector.
module tb_cpu_alu;

  logic       clk;
  logic       reset;
  logic [3:0] operation;
  logic [3:0] flagsIn;
  logic [7:0] leftOperand;
  logic [7:0] rightOperand;
  logic [7:0] resultOut;
  logic [3:0] flagsOut;

  int checks = 0;
  int errors = 0;

  cpu_alu dut (
    .clk          (clk),
    .reset        (reset),
    .operation    (operation),
    .flagsIn      (flagsIn),
    .leftOperand  (leftOperand),
    .rightOperand (rightOperand),
    .resultOut    (resultOut),
    .flagsOut     (flagsOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [7:0] er, input logic [3:0] ef);
    checks++;
    assert (resultOut === er) else begin
      errors++;
      $error("FAIL %s result observed=%02h expected=%02h", tag, resultOut, er);
    end
    checks++;
    assert (flagsOut === ef) else begin
      errors++;
      $error("FAIL %s flags observed=%04b expected=%04b", tag, flagsOut, ef);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [3:0] fin,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef);
    @(negedge clk);
    operation    = op;
    flagsIn      = fin;
    leftOperand  = a;
    rightOperand = b;
    @(posedge clk);
    #1;
    check_out(tag, er, ef);
  endtask

  initial begin
    reset        = 1'b1;
    operation    = 4'h0;
    flagsIn      = 4'h0;
    leftOperand  = 8'h12;
    rightOperand = 8'h34;

    // Reset dominates an ADD in flight.
    @(posedge clk);
    #1;
    check_out("reset", 8'h00, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("first_add", 8'h46, 4'b0000);

    step("add_ovf",   4'h0, 4'b0000, 8'h7F, 8'h01, 8'h80, 4'b1100);
    step("add_carry", 4'h0, 4'b0000, 8'hFF, 8'h01, 8'h00, 4'b0011);
    // Chain: ADC takes carry from the previous flagsOut.
    step("adc_chain", 4'h1, flagsOut, 8'h00, 8'h00, 8'h01, 4'b0000);
    step("adc_cin",   4'h1, 4'b0001, 8'h10, 8'h20, 8'h31, 4'b0000);
    step("sbc_cin",   4'h3, 4'b0001, 8'h10, 8'h10, 8'hFF, 4'b0101);
    step("sbc_zero",  4'h3, 4'b0001, 8'h00, 8'h00, 8'hFF, 4'b0101);
    step("sub_zero",  4'h2, 4'b0000, 8'h05, 8'h05, 8'h00, 4'b0010);
    step("cmp_lt",    4'h7, 4'b0000, 8'h03, 8'h05, 8'h03, 4'b0101);
    step("cmp_eq",    4'h7, 4'b0000, 8'h05, 8'h05, 8'h05, 4'b0010);
    step("sub_ovf",   4'h2, 4'b0000, 8'h80, 8'h01, 8'h7F, 4'b1000);
    step("rol",       4'hC, 4'b0001, 8'h80, 8'h00, 8'h01, 4'b0001);
    step("ror",       4'hD, 4'b0001, 8'h01, 8'h00, 8'h80, 4'b0101);
    step("shr",       4'hB, 4'b0001, 8'h01, 8'h00, 8'h00, 4'b0011);
    step("shl",       4'hA, 4'b0000, 8'h81, 8'h00, 8'h02, 4'b0001);
    step("and_keep",  4'h4, 4'b1001, 8'hF0, 8'h0F, 8'h00, 4'b0011);
    step("or_keep",   4'h5, 4'b1000, 8'h00, 8'h00, 8'h00, 4'b0010);
    step("xor",       4'h6, 4'b0000, 8'hAA, 8'hFF, 8'h55, 4'b0000);
    step("inc_ovf",   4'h8, 4'b1001, 8'h7F, 8'h00, 8'h80, 4'b1101);
    step("dec_ovf",   4'h9, 4'b0001, 8'h80, 8'h00, 8'h7F, 4'b1001);
    step("dec_wrap",  4'h9, 4'b0000, 8'h00, 8'h00, 8'hFF, 4'b0100);
    step("not",       4'hE, 4'b0000, 8'h0F, 8'h00, 8'hF0, 4'b0100);
    step("pass_keep", 4'hF, 4'b1001, 8'h55, 8'h00, 8'h00, 4'b1011);

    // Outputs hold between edges even when inputs change.
    @(negedge clk);
    operation    = 4'h0;
    flagsIn      = 4'b0000;
    leftOperand  = 8'h01;
    rightOperand = 8'h01;
    #1;
    check_out("hold", 8'h00, 4'b1011);
    @(posedge clk);
    #1;
    check_out("after_hold", 8'h02, 4'b0000);

    // Mid-stream reset clears both outputs again.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_again", 8'h00, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
